ysyx_24080006_ex_dispatch: RTL and testbench

Parametrised successor to the single-outstanding execute stage. It accepts issued ops and dispatches each one to one of NUM_FU multi-cycle functional units (LSU, MDU, ...), or completes it immediately as a bypass op. It tracks up to ROB_DEPTH in-flight ops in an in-order completion buffer and retires results in program order to writeback. It also provides rd forwarding from completed-but-unretired entries.

---
 rtl/ysyx_24080006_ex_dispatch_pkg.sv | 22 ++
 rtl/ysyx_24080006_ex_dispatch_if.sv | 61 ++++++
 rtl/ysyx_24080006_fu_req_slot.sv | 44 ++++
 rtl/ysyx_24080006_ex_dispatch.sv | 178 +++++++++++++++++
 tb/tb_ysyx_24080006_ex_dispatch.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24080006_ex_dispatch_pkg.sv
// Shared types for the execute dispatch stage: completion-buffer entry states,
// default geometry and the bypass-target helper.
package ysyx_24080006_ex_dispatch_pkg;

  localparam int DEF_XLEN      = 32;
  localparam int DEF_NUM_FU    = 2;
  localparam int DEF_ROB_DEPTH = 4;
  localparam int DEF_REG_WIDTH = 5;
  localparam int DEF_OP_W      = 4;

  typedef enum logic [1:0] {
    ROB_FREE = 2'd0,
    ROB_PEND = 2'd1,
    ROB_DONE = 2'd2
  } rob_state_e;

  // Any target index at or beyond the FU count completes in the buffer directly.
  function automatic logic fu_is_bypass(input int fu, input int num_fu);
    return fu >= num_fu;
  endfunction

endpackage

// File: rtl/ysyx_24080006_ex_dispatch_if.sv
// Issue / functional-unit / writeback bundle of the execute dispatch stage.
// master = surrounding pipeline and FUs, slave = the dispatch block.
interface ysyx_24080006_ex_dispatch_if
  import ysyx_24080006_ex_dispatch_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int NUM_FU    = DEF_NUM_FU,
  parameter int ROB_DEPTH = DEF_ROB_DEPTH,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int OP_W      = DEF_OP_W
) ();
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int FU_W  = $clog2(NUM_FU + 1);

  logic                    issue_valid;
  logic                    issue_ready;
  logic [FU_W-1:0]         issue_fu;
  logic [OP_W-1:0]         issue_op;
  logic [XLEN-1:0]         issue_a;
  logic [XLEN-1:0]         issue_b;
  logic [REG_WIDTH-1:0]    issue_rd;
  logic                    issue_we;

  logic [NUM_FU-1:0]       fu_req_valid;
  logic [NUM_FU-1:0]       fu_req_ready;
  logic [NUM_FU*XLEN-1:0]  fu_req_a;
  logic [NUM_FU*XLEN-1:0]  fu_req_b;
  logic [NUM_FU*OP_W-1:0]  fu_req_op;
  logic [NUM_FU*TAG_W-1:0] fu_req_tag;

  logic [NUM_FU-1:0]       fu_rsp_valid;
  logic [NUM_FU*TAG_W-1:0] fu_rsp_tag;
  logic [NUM_FU*XLEN-1:0]  fu_rsp_data;

  logic                    wb_valid;
  logic                    wb_ready;
  logic [REG_WIDTH-1:0]    wb_rd;
  logic                    wb_we;
  logic [XLEN-1:0]         wb_data;

  modport master (
    output issue_valid, issue_fu, issue_op, issue_a, issue_b, issue_rd, issue_we,
    input  issue_ready,
    input  fu_req_valid, fu_req_a, fu_req_b, fu_req_op, fu_req_tag,
    output fu_req_ready,
    output fu_rsp_valid, fu_rsp_tag, fu_rsp_data,
    input  wb_valid, wb_rd, wb_we, wb_data,
    output wb_ready
  );

  modport slave (
    input  issue_valid, issue_fu, issue_op, issue_a, issue_b, issue_rd, issue_we,
    output issue_ready,
    output fu_req_valid, fu_req_a, fu_req_b, fu_req_op, fu_req_tag,
    input  fu_req_ready,
    input  fu_rsp_valid, fu_rsp_tag, fu_rsp_data,
    output wb_valid, wb_rd, wb_we, wb_data,
    input  wb_ready
  );

endinterface

// File: rtl/ysyx_24080006_fu_req_slot.sv
// One functional-unit request holding register: loads on dispatch, holds all
// fields stable until the FU signals ready, then drops valid.
module ysyx_24080006_fu_req_slot
  import ysyx_24080006_ex_dispatch_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int OP_W  = DEF_OP_W,
  parameter int TAG_W = $clog2(DEF_ROB_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [XLEN-1:0]  load_a,
  input  logic [XLEN-1:0]  load_b,
  input  logic [OP_W-1:0]  load_op,
  input  logic [TAG_W-1:0] load_tag,
  input  logic             ready,
  output logic             valid,
  output logic [XLEN-1:0]  a,
  output logic [XLEN-1:0]  b,
  output logic [OP_W-1:0]  op,
  output logic [TAG_W-1:0] tag
);

  // load and a pending handshake never coincide: dispatch refuses a busy slot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      tag   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      a     <= load_a;
      b     <= load_b;
      op    <= load_op;
      tag   <= load_tag;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_24080006_ex_dispatch.sv
// Execute dispatch: sends issued ops to NUM_FU multi-cycle units or completes
// bypass ops at once, retires in order from a ROB_DEPTH completion buffer and
// forwards completed results. Define EX_DISPATCH_PERF_EN for the perf counters.
module ysyx_24080006_ex_dispatch
  import ysyx_24080006_ex_dispatch_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int NUM_FU    = DEF_NUM_FU,
  parameter int ROB_DEPTH = DEF_ROB_DEPTH,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int OP_W      = DEF_OP_W
) (
  input  logic                 clock,
  input  logic                 reset,
  ysyx_24080006_ex_dispatch_if.slave bus,
  input  logic [REG_WIDTH-1:0] fwd_rs,
  output logic                 fwd_hit,
  output logic                 fwd_pending,
  output logic [XLEN-1:0]      fwd_data,
  output logic                 busy,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_stall_cnt
);

  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = TAG_W + 1;

  typedef struct packed {
    rob_state_e           state;
    logic [REG_WIDTH-1:0] rd;
    logic                 we;
    logic [XLEN-1:0]      data;
  } rob_entry_t;

  rob_entry_t        rob [ROB_DEPTH];
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              is_bypass;
  logic              fu_busy;
  logic              accept;
  logic              retire;
  logic [NUM_FU-1:0] load;
  logic [TAG_W-1:0]  scan_idx;

  wire  [NUM_FU-1:0]       req_valid;
  wire  [NUM_FU*XLEN-1:0]  req_a;
  wire  [NUM_FU*XLEN-1:0]  req_b;
  wire  [NUM_FU*OP_W-1:0]  req_op;
  wire  [NUM_FU*TAG_W-1:0] req_tag;

  always_comb begin
    is_bypass = fu_is_bypass(int'(bus.issue_fu), NUM_FU);
    fu_busy   = 1'b0;
    load      = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (int'(bus.issue_fu) == f) fu_busy = req_valid[f];
    end
    for (int f = 0; f < NUM_FU; f++) begin
      load[f] = accept && (int'(bus.issue_fu) == f);
    end
  end

  // Readiness looks only at registered occupancy, never at a same-cycle retire.
  assign bus.issue_ready = (count < CNT_W'(ROB_DEPTH)) && (is_bypass || !fu_busy);
  assign accept          = bus.issue_valid && bus.issue_ready;

  assign bus.wb_valid = (rob[head].state == ROB_DONE);
  assign bus.wb_rd    = rob[head].rd;
  assign bus.wb_we    = rob[head].we;
  assign bus.wb_data  = rob[head].data;
  assign retire       = bus.wb_valid && bus.wb_ready;

  assign busy = (count != '0);

  for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
    ysyx_24080006_fu_req_slot #(
      .XLEN (XLEN),
      .OP_W (OP_W),
      .TAG_W(TAG_W)
    ) u_slot (
      .clock   (clock),
      .reset   (reset),
      .load    (load[g]),
      .load_a  (bus.issue_a),
      .load_b  (bus.issue_b),
      .load_op (bus.issue_op),
      .load_tag(tail),
      .ready   (bus.fu_req_ready[g]),
      .valid   (req_valid[g]),
      .a       (req_a[g*XLEN +: XLEN]),
      .b       (req_b[g*XLEN +: XLEN]),
      .op      (req_op[g*OP_W +: OP_W]),
      .tag     (req_tag[g*TAG_W +: TAG_W])
    );
  end

  assign bus.fu_req_valid = req_valid;
  assign bus.fu_req_a     = req_a;
  assign bus.fu_req_b     = req_b;
  assign bus.fu_req_op    = req_op;
  assign bus.fu_req_tag   = req_tag;

  // Retire, responses and allocation touch disjoint slots: head is DONE,
  // responses only land on PEND slots, and tail is FREE when accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
    end else begin
      if (retire) begin
        rob[head].state <= ROB_FREE;
        head            <= head + 1'b1;
      end
      for (int f = 0; f < NUM_FU; f++) begin
        if (bus.fu_rsp_valid[f] &&
            rob[bus.fu_rsp_tag[f*TAG_W +: TAG_W]].state == ROB_PEND) begin
          rob[bus.fu_rsp_tag[f*TAG_W +: TAG_W]].state <= ROB_DONE;
          rob[bus.fu_rsp_tag[f*TAG_W +: TAG_W]].data  <= bus.fu_rsp_data[f*XLEN +: XLEN];
        end
      end
      if (accept) begin
        rob[tail].rd    <= bus.issue_rd;
        rob[tail].we    <= bus.issue_we;
        rob[tail].state <= is_bypass ? ROB_DONE : ROB_PEND;
        rob[tail].data  <= is_bypass ? bus.issue_a : '0;
        tail            <= tail + 1'b1;
      end
      case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_hit     = 1'b0;
    fwd_pending = 1'b0;
    fwd_data    = '0;
    scan_idx    = head;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      scan_idx = head + TAG_W'(i);
      if ((CNT_W'(i) < count) && (fwd_rs != '0) &&
          rob[scan_idx].we && (rob[scan_idx].rd == fwd_rs)) begin
        fwd_hit     = (rob[scan_idx].state == ROB_DONE);
        fwd_pending = (rob[scan_idx].state == ROB_PEND);
        fwd_data    = (rob[scan_idx].state == ROB_DONE) ? rob[scan_idx].data : '0;
      end
    end
  end

`ifdef EX_DISPATCH_PERF_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) issue_cnt <= issue_cnt + 32'd1;
      if (bus.issue_valid && !bus.issue_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_issue_cnt = issue_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_24080006_ex_dispatch.sv
// Directed bench for the execute dispatch stage: an in-order queue model is
// compared every cycle, and literal expectations pin the individual scenarios.
module tb_ysyx_24080006_ex_dispatch;

  localparam int XLEN      = 32;
  localparam int NUM_FU    = 2;
  localparam int ROB_DEPTH = 4;
  localparam int REG_WIDTH = 5;
  localparam int OP_W      = 4;
  localparam int TAG_W     = 2;
  localparam int FU_W      = 2;
  localparam int BYP       = NUM_FU;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ysyx_24080006_ex_dispatch_if #(
    .XLEN(XLEN), .NUM_FU(NUM_FU), .ROB_DEPTH(ROB_DEPTH),
    .REG_WIDTH(REG_WIDTH), .OP_W(OP_W)
  ) bus ();

  logic [REG_WIDTH-1:0] fwd_rs;
  logic                 fwd_hit;
  logic                 fwd_pending;
  logic [XLEN-1:0]      fwd_data;
  logic                 busy;
  logic [31:0]          perf_issue_cnt;
  logic [31:0]          perf_stall_cnt;

  ysyx_24080006_ex_dispatch #(
    .XLEN(XLEN), .NUM_FU(NUM_FU), .ROB_DEPTH(ROB_DEPTH),
    .REG_WIDTH(REG_WIDTH), .OP_W(OP_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .fwd_rs        (fwd_rs),
    .fwd_hit       (fwd_hit),
    .fwd_pending   (fwd_pending),
    .fwd_data      (fwd_data),
    .busy          (busy),
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [REG_WIDTH-1:0] rd;
    logic                 we;
    logic                 done;
    logic [XLEN-1:0]      data;
    int                   tag;
  } ment_t;

  ment_t           mq[$];
  ment_t           me;
  int              m_tail;
  logic            m_rv   [NUM_FU];
  logic [XLEN-1:0] m_ra   [NUM_FU];
  logic [XLEN-1:0] m_rb   [NUM_FU];
  logic [OP_W-1:0] m_rop  [NUM_FU];
  int              m_rtag [NUM_FU];
  logic [31:0]     m_issue;
  logic [31:0]     m_stall;
  logic            m_rdy, m_acc, m_ret;
  int              m_fu;

  function automatic logic model_ready();
    int fu;
    fu = int'(bus.issue_fu);
    if (fu >= NUM_FU) return mq.size() < ROB_DEPTH;
    return (mq.size() < ROB_DEPTH) && !m_rv[fu];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_tail  = 0;
      m_issue = '0;
      m_stall = '0;
      for (int f = 0; f < NUM_FU; f++) begin
        m_rv[f] = 1'b0; m_ra[f] = '0; m_rb[f] = '0; m_rop[f] = '0; m_rtag[f] = 0;
      end
    end else begin
      m_rdy = model_ready();
      m_acc = bus.issue_valid && m_rdy;
      m_ret = (mq.size() > 0) && mq[0].done && bus.wb_ready;
      for (int f = 0; f < NUM_FU; f++) begin
        if (bus.fu_rsp_valid[f]) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == int'(bus.fu_rsp_tag[f*TAG_W +: TAG_W]) && !mq[i].done) begin
              me      = mq[i];
              me.done = 1'b1;
              me.data = bus.fu_rsp_data[f*XLEN +: XLEN];
              mq[i]   = me;
            end
          end
        end
        if (m_rv[f] && bus.fu_req_ready[f]) m_rv[f] = 1'b0;
      end
      if (bus.issue_valid && !m_rdy) m_stall = m_stall + 32'd1;
      if (m_acc) begin
        m_fu = int'(bus.issue_fu);
        if (m_fu < NUM_FU) begin
          m_rv[m_fu]   = 1'b1;
          m_ra[m_fu]   = bus.issue_a;
          m_rb[m_fu]   = bus.issue_b;
          m_rop[m_fu]  = bus.issue_op;
          m_rtag[m_fu] = m_tail;
        end
        me.rd   = bus.issue_rd;
        me.we   = bus.issue_we;
        me.done = (m_fu >= NUM_FU);
        me.data = bus.issue_a;
        me.tag  = m_tail;
        mq.push_back(me);
        m_tail  = (m_tail + 1) % ROB_DEPTH;
        m_issue = m_issue + 32'd1;
      end
      if (m_ret) void'(mq.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  logic            cmp_on = 1'b0;
  logic            e_wbv, e_hit, e_pend;
  logic [XLEN-1:0] e_fdata;

  always @(negedge clock) begin
    if (cmp_on) begin
      e_wbv = (mq.size() > 0) && mq[0].done;
      chk("m_wb_valid", bus.wb_valid, e_wbv);
      if (e_wbv) begin
        chk("m_wb_rd", bus.wb_rd, mq[0].rd);
        chk("m_wb_we", bus.wb_we, mq[0].we);
        chk("m_wb_data", bus.wb_data, mq[0].data);
      end
      chk("m_busy", busy, mq.size() != 0);
      chk("m_issue_ready", bus.issue_ready, model_ready());
      for (int f = 0; f < NUM_FU; f++) begin
        chk("m_req_valid", bus.fu_req_valid[f], m_rv[f]);
        if (m_rv[f]) begin
          chk("m_req_a", bus.fu_req_a[f*XLEN +: XLEN], m_ra[f]);
          chk("m_req_b", bus.fu_req_b[f*XLEN +: XLEN], m_rb[f]);
          chk("m_req_op", bus.fu_req_op[f*OP_W +: OP_W], m_rop[f]);
          chk("m_req_tag", bus.fu_req_tag[f*TAG_W +: TAG_W], m_rtag[f]);
        end
      end
      e_hit = 1'b0; e_pend = 1'b0; e_fdata = '0;
      if (fwd_rs != '0) begin
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (mq[i].we && mq[i].rd == fwd_rs) begin
            e_hit = mq[i].done; e_pend = !mq[i].done; e_fdata = mq[i].data;
            break;
          end
        end
      end
      chk("m_fwd_hit", fwd_hit, e_hit);
      chk("m_fwd_pending", fwd_pending, e_pend);
      if (e_hit) chk("m_fwd_data", fwd_data, e_fdata);
`ifdef EX_DISPATCH_PERF_EN
      chk("m_perf_issue", perf_issue_cnt, m_issue);
      chk("m_perf_stall", perf_stall_cnt, m_stall);
`else
      chk("m_perf_issue", perf_issue_cnt, 32'd0);
      chk("m_perf_stall", perf_stall_cnt, 32'd0);
`endif
    end
  end

  logic [XLEN-1:0] got[$];
  always @(posedge clock) begin
    if (reset && bus.wb_valid && bus.wb_ready) got.push_back(bus.wb_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.issue_valid  = 1'b0;
    bus.fu_rsp_valid = '0;
    bus.wb_ready     = 1'b0;
    bus.fu_req_ready = '1;
    fwd_rs           = '0;
    reset            = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic issue(input int fu, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [OP_W-1:0] op, input logic [REG_WIDTH-1:0] rd,
                       input logic we);
    bus.issue_valid = 1'b1;
    bus.issue_fu    = FU_W'(fu);
    bus.issue_a     = a;
    bus.issue_b     = b;
    bus.issue_op    = op;
    bus.issue_rd    = rd;
    bus.issue_we    = we;
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic respond(input int fu, input int tag, input logic [XLEN-1:0] data);
    bus.fu_rsp_valid                    = '0;
    bus.fu_rsp_valid[fu]                = 1'b1;
    bus.fu_rsp_tag[fu*TAG_W +: TAG_W]   = TAG_W'(tag);
    bus.fu_rsp_data[fu*XLEN +: XLEN]    = data;
    tick();
    bus.fu_rsp_valid = '0;
  endtask

  initial begin
    bus.issue_valid  = 1'b0;
    bus.issue_fu     = '0;
    bus.issue_op     = '0;
    bus.issue_a      = '0;
    bus.issue_b      = '0;
    bus.issue_rd     = '0;
    bus.issue_we     = 1'b0;
    bus.fu_req_ready = '1;
    bus.fu_rsp_valid = '0;
    bus.fu_rsp_tag   = '0;
    bus.fu_rsp_data  = '0;
    bus.wb_ready     = 1'b0;
    fwd_rs           = '0;

    tick();
    cmp_on = 1'b1;
    chk("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_valid", bus.fu_req_valid, 2'b00);
    chk("rst_wb_data", bus.wb_data, 32'h0);
    tick();
    reset = 1'b1;

    // bypass: completes one cycle after issue
    issue(BYP, 32'h1234, 32'h0, 4'h0, 5'd5, 1'b1);
    chk("byp_wb_valid", bus.wb_valid, 1'b1);
    chk("byp_wb_rd", bus.wb_rd, 5'd5);
    chk("byp_wb_data", bus.wb_data, 32'h1234);
    chk("byp_busy", busy, 1'b1);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk("byp_busy_after", busy, 1'b0);

    // out-of-order completion, in-order retirement
    do_reset();
    issue(1, 32'h1, 32'h2, 4'h3, 5'd1, 1'b1);
    chk("ooo_fu1_valid", bus.fu_req_valid[1], 1'b1);
    chk("ooo_fu1_tag", bus.fu_req_tag[3:2], 2'd0);
    issue(0, 32'h4, 32'h5, 4'h6, 5'd2, 1'b1);
    chk("ooo_req_valid", bus.fu_req_valid, 2'b01);
    chk("ooo_fu0_tag", bus.fu_req_tag[1:0], 2'd1);
    respond(0, 1, 32'hAA);
    chk("ooo_head_wait", bus.wb_valid, 1'b0);
    tick();
    tick();
    respond(1, 0, 32'hBB);
    got.delete();
    bus.wb_ready = 1'b1;
    for (int k = 0; k < 8 && got.size() < 2; k++) tick();
    bus.wb_ready = 1'b0;
    chk("ooo_count", got.size(), 2);
    chk("ooo_first", got.size() > 0 ? got[0] : 32'hDEAD_DEAD, 32'hBB);
    chk("ooo_second", got.size() > 1 ? got[1] : 32'hDEAD_DEAD, 32'hAA);

    // full buffer: retire frees a slot only from the next cycle
    do_reset();
    for (int i = 1; i <= 4; i++) issue(BYP, 32'(i * 16), 32'h0, 4'h0, 5'(i), 1'b1);
    bus.issue_valid = 1'b1;
    bus.issue_fu    = FU_W'(BYP);
    bus.issue_a     = 32'h50;
    bus.issue_rd    = 5'd5;
    #1;
    chk("full_ready", bus.issue_ready, 1'b0);
    tick();
    bus.wb_ready = 1'b1;
    #1;
    chk("full_ready_same_cycle", bus.issue_ready, 1'b0);
    tick();
    bus.wb_ready = 1'b0;
    #1;
    chk("full_ready_next", bus.issue_ready, 1'b1);
    tick();
    bus.issue_valid = 1'b0;
    chk("full_busy", busy, 1'b1);
    bus.wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    bus.wb_ready = 1'b0;
    chk("full_drained", busy, 1'b0);

    // backpressure on FU0
    do_reset();
    bus.fu_req_ready = 2'b10;
    issue(0, 32'hA5, 32'h5A, 4'h3, 5'd9, 1'b1);
    bus.issue_valid = 1'b1;
    bus.issue_fu    = FU_W'(0);
    bus.issue_a     = 32'h77;
    bus.issue_rd    = 5'd10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", bus.fu_req_valid[0], 1'b1);
      chk("bp_a", bus.fu_req_a[31:0], 32'hA5);
      chk("bp_b", bus.fu_req_b[31:0], 32'h5A);
      chk("bp_op", bus.fu_req_op[3:0], 4'h3);
      chk("bp_tag", bus.fu_req_tag[1:0], 2'd0);
      chk("bp_refuse", bus.issue_ready, 1'b0);
      tick();
    end
    bus.issue_valid  = 1'b0;
    bus.fu_req_ready = '1;
    tick();
    chk("bp_clear", bus.fu_req_valid[0], 1'b0);

    // forwarding
    do_reset();
    fwd_rs = 5'd7;
    issue(1, 32'h11, 32'h22, 4'h1, 5'd7, 1'b1);
    chk("fwd_pending", fwd_pending, 1'b1);
    chk("fwd_pend_nohit", fwd_hit, 1'b0);
    respond(1, 0, 32'h55);
    chk("fwd_hit", fwd_hit, 1'b1);
    chk("fwd_data", fwd_data, 32'h55);
    chk("fwd_not_pending", fwd_pending, 1'b0);
    issue(BYP, 32'h66, 32'h0, 4'h0, 5'd7, 1'b1);
    chk("fwd_young_hit", fwd_hit, 1'b1);
    chk("fwd_young_data", fwd_data, 32'h66);
    fwd_rs = 5'd0;
    #1;
    chk("fwd_x0_hit", fwd_hit, 1'b0);
    chk("fwd_x0_pending", fwd_pending, 1'b0);

    // asynchronous reset with two ops in flight
    do_reset();
    issue(0, 32'h1, 32'h1, 4'h1, 5'd1, 1'b1);
    issue(1, 32'h2, 32'h2, 4'h2, 5'd2, 1'b1);
    chk("mid_busy_before", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_wb_valid", bus.wb_valid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_req_valid", bus.fu_req_valid, 2'b00);
    respond(0, 0, 32'h99);
    tick();
    reset = 1'b1;
    respond(0, 0, 32'h77);
    respond(1, 1, 32'h88);
    tick();
    chk("mid_stale_wb", bus.wb_valid, 1'b0);
    chk("mid_stale_busy", busy, 1'b0);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
